rom_loader: RTL
===============

# rom_loader

Boot-time program loader that fills the core's instruction memory from a byte stream before releasing the core from reset. It accepts a length-prefixed little-endian byte stream over a valid/ready handshake, assembles 32-bit words, and issues one write per word into the ROM/instruction RAM at the reset vector. It keeps the core in reset until the load finishes, so the core's first fetch sees the new image.

## Interface
- `ADDR_BASE`, default `32'h8000_0000`: byte address of the first word written; equals the core reset PC.
- `DEPTH_WORDS`, default `4096`: capacity of the instruction memory in words; larger lengths are rejected.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse that begins a load.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader can accept a byte; a transfer occurs when `in_valid && in_ready`.
- `mem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `mem_addr`  out  32  byte address of the write.
- `mem_wdata`  out  32  word to write.
- `core_reset_n`  out  1  active-low reset to the core; held low until the load completes.
- `busy`  out  1  high while in LEN or DATA.
- `done`  out  1  high after a successful load.
- `error`  out  1  high after a rejected length.

## Operation
- States: IDLE, LEN, DATA, DONE, ERROR.
- Reset behaviour:
  - state = IDLE.
  - `in_ready` = 0, `mem_we` = 0, `mem_addr` = `ADDR_BASE`, `mem_wdata` = 0.
  - `core_reset_n` = 0, `busy` = 0, `done` = 0, `error` = 0.
  - Byte counter, word index and length register all clear to 0.
- IDLE:
  - `start` → LEN; clear the byte counter, the word index and `done`/`error`.
- LEN:
  - `in_ready` = 1. Accept 4 bytes, little-endian (first byte is bits [7:0]), to form `len` as a word count.
  - After the 4th byte:
    - `len` == 0 → DONE.
    - `len` > `DEPTH_WORDS` → ERROR.
    - Otherwise → DATA.
- DATA:
  - `in_ready` = 1. Shift bytes in little-endian order into a word register.
  - On the 4th byte of word `i`, register `mem_wdata` = word, `mem_addr` = `ADDR_BASE` + 4·`i`, and `mem_we` = 1 for exactly the next cycle.
  - After the byte that completes word `len`-1 → DONE. `in_ready` is 0 from the following cycle.
- DONE:
  - `done` = 1, `core_reset_n` = 1, `in_ready` = 0. Extra stream bytes are not accepted.
- ERROR:
  - `error` = 1, `core_reset_n` = 0, `in_ready` = 0.
- `start` in DONE or ERROR:
  - Restarts into LEN and drops `core_reset_n` to 0 on the next cycle.
- `start` in LEN or DATA: ignored.
- Stalls: gaps in `in_valid` stall the assembly. Partial words and partial lengths are kept indefinitely; there is no timeout.
- Address arithmetic is 32-bit with wrap, but it cannot wrap because `len` ≤ `DEPTH_WORDS`.
- Word index width is clog2(`DEPTH_WORDS`+1).
- `reset` at any time, including mid-word or mid-length, returns immediately to IDLE with the reset values above. Any partial word is discarded and no write is issued.

## Timing
- Byte throughput: one byte per cycle when `in_valid` is held high. Each word therefore needs 4 cycles, with no bubble between words.
- Write latency: `mem_we` is high in the cycle after the handshake of the word's 4th byte. `mem_addr`/`mem_wdata` are valid in that same cycle and hold until the next write.
- State transition to DONE happens on the same edge as the final byte's handshake. As a result, `done` and `core_reset_n` rise in the same cycle as the final `mem_we`, and the memory write commits on that cycle's edge.
- Memory timing: the core comes out of reset on the edge after that; its first fetch is from `ADDR_BASE`.
- Zero length: `done` and `core_reset_n` rise in the cycle after the 4th length byte.
- Oversize length: `error` rises in the cycle after the 4th length byte, and `in_ready` goes low in that same cycle.
- `busy` follows the state (LEN or DATA) with no extra delay.

## Test plan
- Normal load:
  - Stimulus: `start`, then stream 02 00 00 00, 13 00 00 00, 6F 00 00 00.
  - Response: `mem_we` pulses with (`8000_0000`, `0000_0013`) then (`8000_0004`, `0000_006F`); `done`=1 and `core_reset_n`=1 after the last byte; `in_ready`=0 afterwards.
- Backpressure gaps:
  - Stimulus: same stream with `in_valid` deasserted for 1–3 random cycles between bytes.
  - Response: identical writes and data; no write happens until 4 bytes of a word have been accepted.
- Zero length:
  - Stimulus: `start`, then 00 00 00 00.
  - Response: no `mem_we`; `done`=1 and `core_reset_n`=1 one cycle after the 4th byte.
- Oversize length:
  - Stimulus: `DEPTH_WORDS`=4, length 05 00 00 00.
  - Response: `error`=1, `in_ready`=0, `core_reset_n` stays 0, no writes. A following `start` re-enters LEN.
- Reset mid-word:
  - Stimulus: assert `reset` after 2 data bytes of word 0.
  - Response: all outputs at reset values immediately; no `mem_we`. A new `start` and a full load then writes from `8000_0000`.
- Reload from DONE:
  - Stimulus: `start` in DONE.
  - Response: `core_reset_n`=0 and `done`=0 next cycle; the second image overwrites from `ADDR_BASE`.

Source files
------------

// File: rtl/rom_loader.sv
// rom_loader: loads a length-prefixed little-endian byte stream into instruction memory, holding the core in reset until done
module rom_loader #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_reset_n,
  output logic        busy,
  output logic        done,
  output logic        error
);
  localparam int IW = $clog2(DEPTH_WORDS + 1);
  localparam logic [IW-1:0] ONE = 1;
  typedef enum logic [2:0] {IDLE, LEN, DATA, DONE, ERROR} state_t;
  state_t state, state_nx;
  logic [1:0]    cnt;
  logic [IW-1:0] idx, len_q;
  logic [23:0]   sh;
  logic [31:0]   wn;
  logic          fire, last, restart;
  assign wn      = {in_data, sh};
  assign fire    = in_valid && in_ready;
  assign last    = cnt == 2'd3;
  assign restart = start && (state == IDLE || state == DONE || state == ERROR);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? LEN : IDLE;
      LEN:     if (fire && last) state_nx = wn == 32'd0 ? DONE : wn > 32'(DEPTH_WORDS) ? ERROR : DATA;
      DATA:    if (fire && last && idx + ONE == len_q) state_nx = DONE;
      default: state_nx = start ? LEN : state;
    endcase
  end
  always_comb begin
    in_ready     = state == LEN || state == DATA;
    busy         = state == LEN || state == DATA;
    done         = state == DONE;
    error        = state == ERROR;
    core_reset_n = state == DONE;
  end
  // Bytes shift in from the top so the first byte ends up in bits [7:0]
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt       <= '0;
      idx       <= '0;
      len_q     <= '0;
      sh        <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= ADDR_BASE;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (restart) begin
        cnt <= '0;
        idx <= '0;
      end else if (fire) begin
        cnt <= cnt + 2'd1;
        sh  <= wn[31:8];
        if (last && state == LEN) len_q <= wn[IW-1:0];
        if (last && state == DATA) begin
          mem_we    <= 1'b1;
          mem_wdata <= wn;
          mem_addr  <= ADDR_BASE + 32'({idx, 2'b00});
          idx       <= idx + ONE;
        end
      end
    end
endmodule
